mem_access_responder: RTL and testbench

- Memory-side responder sitting behind the 3-requestor round-robin arbiter.
- Samples the arbiter's one-hot grant, captures the granted requestor's address, write data and write enable, then performs one access on an internal word array.
- Returns a one-cycle response pulse, with read data, to the granted requestor only.
- Single outstanding transaction; grants arriving while busy are ignored, and the arbiter re-grants later.

---
 rtl/mem_access_responder_if.sv | 25 ++
 rtl/mem_access_responder.sv | 150 +++++++++++++++
 tb/tb_mem_access_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_responder_if.sv
// rtl/mem_access_responder_if.sv - grant/request/response bundle between arbiter and memory responder
interface mem_access_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [2:0]          grant;
    logic [3*ADDR_W-1:0] req_addr;
    logic [3*DATA_W-1:0] req_wdata;
    logic [2:0]          req_we;
    logic [2:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                busy;
    logic                err;
    logic [1:0]          resp_state;

    modport master (
        output grant, req_addr, req_wdata, req_we,
        input  rsp_valid, rsp_rdata, busy, err, resp_state
    );

    modport slave (
        input  grant, req_addr, req_wdata, req_we,
        output rsp_valid, rsp_rdata, busy, err, resp_state
    );
endinterface

// File: rtl/mem_access_responder.sv
// rtl/mem_access_responder.sv - single-outstanding memory responder behind a 3-way arbiter
// Optional RESP_PARITY_EN adds rsp_parity, the XOR of rsp_rdata.
module mem_access_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    mem_access_responder_if.slave bus
`ifdef RESP_PARITY_EN
    ,
    output logic rsp_parity
`endif
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_t;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] CNT_INIT = (RD_LAT >= 2) ? 2'(RD_LAT - 2) : 2'd0;

    state_t            state;
    logic [1:0]        id_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    logic              we_q;
    logic              addr_ok_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        gnt_id;
    logic              gnt_onehot;
    logic [ADDR_W-1:0] gnt_addr;
    logic              gnt_addr_ok;
    logic [DATA_W-1:0] rd_word;
    logic              rdata_load;
    logic [DATA_W-1:0] rdata_next;

    always_comb begin
        gnt_id = 2'd0;
        case (bus.grant)
            3'b010:  gnt_id = 2'd1;
            3'b100:  gnt_id = 2'd2;
            default: gnt_id = 2'd0;
        endcase
    end

    assign gnt_onehot  = $onehot(bus.grant);
    assign gnt_addr    = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
    assign gnt_addr_ok = int'({1'b0, gnt_addr}) < DEPTH;

    // Out-of-range reads return zero but still complete with a response.
    always_comb begin
        rd_word    = addr_ok_q ? mem[addr_q[IDX_W-1:0]] : '0;
        rdata_load = 1'b0;
        rdata_next = rd_word;
        if (state == ACCESS && !we_q && RD_LAT == 1) begin
            rdata_load = 1'b1;
        end else if (state == WAIT && cnt_q == 2'd0) begin
            rdata_load = 1'b1;
            rdata_next = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && we_q && addr_ok_q) begin
            mem[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            id_q           <= 2'd0;
            cnt_q          <= 2'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            we_q           <= 1'b0;
            addr_ok_q      <= 1'b0;
            bus.rsp_valid  <= 3'b000;
            bus.rsp_rdata  <= '0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.rsp_valid <= 3'b000;
            bus.err       <= 1'b0;
            if (rdata_load) begin
                bus.rsp_rdata <= rdata_next;
            end
            case (state)
                IDLE: begin
                    if (gnt_onehot) begin
                        id_q      <= gnt_id;
                        addr_q    <= gnt_addr;
                        wdata_q   <= bus.req_wdata[int'(gnt_id)*DATA_W +: DATA_W];
                        we_q      <= bus.req_we[gnt_id];
                        addr_ok_q <= gnt_addr_ok;
                        bus.err   <= !gnt_addr_ok;
                        bus.busy  <= 1'b1;
                        state     <= ACCESS;
                    end else if (bus.grant != 3'b000) begin
                        bus.err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (we_q || RD_LAT == 1) begin
                        bus.rsp_valid <= 3'b001 << id_q;
                        state         <= RESP;
                    end else begin
                        rd_q  <= rd_word;
                        cnt_q <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        bus.rsp_valid <= 3'b001 << id_q;
                        state         <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_state = state;

`ifdef RESP_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_parity <= 1'b0;
        end else if (rdata_load) begin
            rsp_parity <= ^rdata_next;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_responder.sv
// tb/tb_mem_access_responder.sv - bench for mem_access_responder across RD_LAT 1..4 and DEPTH 128/256
module tb_mem_access_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  grant = 3'b000;
    logic [23:0] req_addr = '0;
    logic [47:0] req_wdata = '0;
    logic [2:0]  req_we = 3'b000;

    logic [2:0]  dv [4];
    logic [15:0] dr [4];
    logic        db [4];
    logic        de [4];
    logic [1:0]  ds [4];
`ifdef RESP_PARITY_EN
    logic        dp [4];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Instance k has RD_LAT=k+1; instance 1 keeps the default DEPTH, the others use 128.
    for (genvar k = 0; k < 4; k++) begin : g
        mem_access_responder_if #(.ADDR_W(8), .DATA_W(16)) bus ();
        assign bus.grant     = grant;
        assign bus.req_addr  = req_addr;
        assign bus.req_wdata = req_wdata;
        assign bus.req_we    = req_we;
        assign dv[k] = bus.rsp_valid;
        assign dr[k] = bus.rsp_rdata;
        assign db[k] = bus.busy;
        assign de[k] = bus.err;
        assign ds[k] = bus.resp_state;
        mem_access_responder #(
            .ADDR_W(8), .DATA_W(16), .DEPTH((k == 1) ? 256 : 128), .RD_LAT(k + 1)
        ) dut (
            .clk(clk),
            .reset(rst),
            .bus(bus)
`ifdef RESP_PARITY_EN
            ,
            .rsp_parity(dp[k])
`endif
        );
    end

    // Reference model: one transaction per instance, timed by its total latency.
    bit          m_act [4];
    int          m_el [4];
    int          m_id [4];
    bit          m_we [4];
    int          m_addr [4];
    logic [15:0] m_wdata [4];
    logic [15:0] m_mem [4][256];
    bit          m_known [4][256];
    logic [2:0]  m_valid [4];
    logic [15:0] m_rdata [4];
    bit          m_rknown [4];
    bit          m_err [4];
    logic [1:0]  m_state [4];

    function automatic int lat_of(int k);
        return k + 1;
    endfunction

    function automatic int dep_of(int k);
        return (k == 1) ? 256 : 128;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int tot;
            int gid;
            m_valid[k] = 3'b000;
            m_err[k]   = 1'b0;
            if (rst) begin
                m_act[k]    = 1'b0;
                m_rdata[k]  = 16'h0;
                m_rknown[k] = 1'b1;
                m_state[k]  = 2'd0;
            end else if (m_act[k]) begin
                tot = m_we[k] ? 2 : 1 + lat_of(k);
                m_el[k]++;
                if (m_el[k] == 1 && m_we[k] && m_addr[k] < dep_of(k)) begin
                    m_mem[k][m_addr[k]]   = m_wdata[k];
                    m_known[k][m_addr[k]] = 1'b1;
                end
                if (m_el[k] == tot - 1) begin
                    m_valid[k] = 3'b001 << m_id[k];
                    m_state[k] = 2'd3;
                    if (!m_we[k]) begin
                        if (m_addr[k] < dep_of(k)) begin
                            m_rdata[k]  = m_mem[k][m_addr[k]];
                            m_rknown[k] = m_known[k][m_addr[k]];
                        end else begin
                            m_rdata[k]  = 16'h0;
                            m_rknown[k] = 1'b1;
                        end
                    end
                end else if (m_el[k] == tot) begin
                    m_act[k]   = 1'b0;
                    m_state[k] = 2'd0;
                end else begin
                    m_state[k] = 2'd2;
                end
            end else begin
                gid = -1;
                case (grant)
                    3'b001: gid = 0;
                    3'b010: gid = 1;
                    3'b100: gid = 2;
                    default: gid = -1;
                endcase
                if (gid >= 0) begin
                    m_act[k]   = 1'b1;
                    m_el[k]    = 0;
                    m_id[k]    = gid;
                    m_we[k]    = req_we[gid];
                    m_addr[k]  = int'(req_addr[gid*8 +: 8]);
                    m_wdata[k] = req_wdata[gid*16 +: 16];
                    m_err[k]   = m_addr[k] >= dep_of(k);
                    m_state[k] = 2'd1;
                end else begin
                    m_err[k]   = grant != 3'b000;
                    m_state[k] = 2'd0;
                end
            end
        end
    endtask

    logic [2:0]  last_v0;
    logic [15:0] last_r0;
    bit          err_seen0;

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rsp_valid[%0d]", k), 32'(dv[k]), 32'(m_valid[k]));
            chk($sformatf("busy[%0d]", k), 32'(db[k]), 32'(m_act[k]));
            chk($sformatf("err[%0d]", k), 32'(de[k]), 32'(m_err[k]));
            chk($sformatf("resp_state[%0d]", k), 32'(ds[k]), 32'(m_state[k]));
            if (m_rknown[k]) begin
                chk($sformatf("rsp_rdata[%0d]", k), 32'(dr[k]), 32'(m_rdata[k]));
`ifdef RESP_PARITY_EN
                chk($sformatf("rsp_parity[%0d]", k), 32'(dp[k]), 32'(^m_rdata[k]));
`endif
            end
        end
        if (dv[0] != 3'b000) begin
            last_v0 = dv[0];
            last_r0 = dr[0];
        end
        if (de[0]) err_seen0 = 1'b1;
    endtask

    task automatic txn(logic [2:0] g, logic [2:0] we, logic [7:0] a, logic [15:0] wd);
        err_seen0 = 1'b0;
        last_v0   = 3'b000;
        grant     = g;
        req_we    = we;
        req_addr  = {3{a}};
        req_wdata = {3{wd}};
        cycle();
        grant = 3'b000;
        for (int i = 0; i < 7; i++) cycle();
    endtask

    typedef struct {
        bit        rst;
        bit [2:0]  g;
        bit [2:0]  we;
        bit [7:0]  a;
        bit [15:0] wd;
        bit [2:0]  ev;
        bit [15:0] er;
        bit        eb;
        bit        ee;
        bit [1:0]  es;
    } vec_t;

    vec_t tbl [28];

    initial begin
        // Expected outputs of the RD_LAT=2 / DEPTH=256 instance after each clock edge.
        tbl[0]  = '{1, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 0, 0, 2'd0};
        tbl[1]  = '{0, 3'b001, 3'b111, 8'h10, 16'hBEEF, 3'b000, 16'h0000, 1, 0, 2'd1};
        tbl[2]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b001, 16'h0000, 1, 0, 2'd3};
        tbl[3]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 0, 0, 2'd0};
        tbl[4]  = '{0, 3'b010, 3'b000, 8'h10, 16'h0000, 3'b000, 16'h0000, 1, 0, 2'd1};
        tbl[5]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 1, 0, 2'd2};
        tbl[6]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b010, 16'hBEEF, 1, 0, 2'd3};
        tbl[7]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'hBEEF, 0, 0, 2'd0};
        tbl[8]  = '{0, 3'b011, 3'b000, 8'h10, 16'h0000, 3'b000, 16'hBEEF, 0, 1, 2'd0};
        tbl[9]  = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'hBEEF, 0, 0, 2'd0};
        tbl[10] = '{0, 3'b001, 3'b000, 8'h10, 16'h0000, 3'b000, 16'hBEEF, 1, 0, 2'd1};
        tbl[11] = '{0, 3'b100, 3'b000, 8'h10, 16'h0000, 3'b000, 16'hBEEF, 1, 0, 2'd2};
        tbl[12] = '{0, 3'b100, 3'b000, 8'h10, 16'h0000, 3'b001, 16'hBEEF, 1, 0, 2'd3};
        tbl[13] = '{0, 3'b100, 3'b000, 8'h10, 16'h0000, 3'b000, 16'hBEEF, 0, 0, 2'd0};
        tbl[14] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'hBEEF, 0, 0, 2'd0};
        tbl[15] = '{0, 3'b100, 3'b111, 8'h20, 16'h1234, 3'b000, 16'hBEEF, 1, 0, 2'd1};
        tbl[16] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b100, 16'hBEEF, 1, 0, 2'd3};
        tbl[17] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'hBEEF, 0, 0, 2'd0};
        tbl[18] = '{0, 3'b001, 3'b000, 8'h20, 16'h0000, 3'b000, 16'hBEEF, 1, 0, 2'd1};
        tbl[19] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'hBEEF, 1, 0, 2'd2};
        tbl[20] = '{1, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 0, 0, 2'd0};
        tbl[21] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 0, 0, 2'd0};
        tbl[22] = '{0, 3'b010, 3'b000, 8'h20, 16'h0000, 3'b000, 16'h0000, 1, 0, 2'd1};
        tbl[23] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h0000, 1, 0, 2'd2};
        tbl[24] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b010, 16'h1234, 1, 0, 2'd3};
        tbl[25] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h1234, 0, 0, 2'd0};
        tbl[26] = '{0, 3'b111, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h1234, 0, 1, 2'd0};
        tbl[27] = '{0, 3'b000, 3'b000, 8'h00, 16'h0000, 3'b000, 16'h1234, 0, 0, 2'd0};

        for (int i = 0; i < 28; i++) begin
            rst       = tbl[i].rst;
            grant     = tbl[i].g;
            req_we    = tbl[i].we;
            req_addr  = {3{tbl[i].a}};
            req_wdata = {3{tbl[i].wd}};
            cycle();
            chk($sformatf("tbl%0d.valid", i), 32'(dv[1]), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d.rdata", i), 32'(dr[1]), 32'(tbl[i].er));
            chk($sformatf("tbl%0d.busy", i), 32'(db[1]), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d.err", i), 32'(de[1]), 32'(tbl[i].ee));
            chk($sformatf("tbl%0d.state", i), 32'(ds[1]), 32'(tbl[i].es));
`ifdef RESP_PARITY_EN
            chk($sformatf("tbl%0d.parity", i), 32'(dp[1]), 32'(^tbl[i].er));
`endif
        end
        rst = 1'b0;

        // Out-of-range handling on the DEPTH=128, RD_LAT=1 instance: no aliasing onto 0x70.
        txn(3'b100, 3'b111, 8'h70, 16'h5A5A);
        txn(3'b100, 3'b111, 8'hF0, 16'hFFFF);
        chk("oor_write_err", 32'(err_seen0), 32'd1);
        txn(3'b001, 3'b000, 8'h70, 16'h0000);
        chk("alias_rdata", 32'(last_r0), 32'h5A5A);
        chk("alias_valid", 32'(last_v0), 32'b001);
        txn(3'b100, 3'b000, 8'hF0, 16'h0000);
        chk("oor_read_rdata", 32'(last_r0), 32'h0);
        chk("oor_read_valid", 32'(last_v0), 32'b100);
        chk("oor_read_err", 32'(err_seen0), 32'd1);

        // Rotating arbiter: grant moves every cycle, each instance accepts only when idle.
        for (int c = 0; c < 60; c++) begin
            grant     = 3'b001 << (c % 3);
            req_we    = 3'($urandom_range(0, 7));
            req_addr  = {8'h70, 8'h20, 8'h10};
            req_wdata = {16'($urandom), 16'($urandom), 16'($urandom)};
            cycle();
        end

        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [7:0] picks [7];
            picks = '{8'h10, 8'h20, 8'h70, 8'hF0, 8'h7F, 8'h80, 8'h00};
            rst = ($urandom_range(0, 99) == 0);
            r = $urandom_range(0, 9);
            if (r < 4) grant = 3'b000;
            else if (r < 9) grant = 3'b001 << $urandom_range(0, 2);
            else grant = 3'($urandom);
            req_we = 3'($urandom);
            for (int j = 0; j < 3; j++) begin
                req_addr[j*8 +: 8]   = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                                                  : picks[$urandom_range(0, 6)];
                req_wdata[j*16 +: 16] = 16'($urandom);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
